// File: rtl/period_scan_ctrl.sv
// period_scan_ctrl: scans the string inputs, routes one wave at a time through a
// synchronizer, averages 2^AVG_LOG2 rising-edge-to-rising-edge intervals (in clk
// cycles) and hands one result per channel to the consumer over valid/ready.
module period_scan_ctrl #(
    parameter int NUM_CH   = 6,
    parameter int CNT_W    = 20,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 4,
    parameter int TIMEOUT  = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] wave_in,
    input  logic              enable,
    input  logic              auto_scan,
    input  logic [2:0]        ch_sel,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [CNT_W-1:0]  res_period,
    output logic              res_timeout,
    output logic              busy,
    output logic [2:0]        cur_ch
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_MEASURE,
        S_PRESENT
    } state_t;

    state_t            r_state;
    logic [SET_W-1:0]  r_settle;
    logic [CNT_W-1:0]  r_per;
    logic [CNT_W-1:0]  r_tmo;
    logic [SMP_W-1:0]  r_smp;
    logic [ACC_W-1:0]  r_acc;
    logic [2:0]        r_cur_ch;
    logic [2:0]        r_next_ch;
    logic              r_s1, r_s2, r_s3;
    logic              r_res_valid;
    logic [2:0]        r_res_ch;
    logic [CNT_W-1:0]  r_res_period;
    logic              r_res_timeout;
    logic              r_busy;

    logic [7:0]        w_wave_pad;
    logic              w_rise;
    logic              w_tmo_hit;
    logic [2:0]        w_load_ch;
    logic [2:0]        w_next_after;
    logic [CNT_W-1:0]  w_per_inc;
    logic [ACC_W-1:0]  w_sum;

    assign w_wave_pad   = 8'(wave_in);
    assign w_rise       = r_s2 & ~r_s3;
    assign w_tmo_hit    = (r_tmo == TMO_LAST);
    assign w_per_inc    = (r_per == CNT_MAX) ? r_per : r_per + 1'b1;
    assign w_sum        = r_acc + ACC_W'(r_per);
    assign w_next_after = (w_load_ch == CH_LAST) ? 3'd0 : w_load_ch + 3'd1;

    // Channel to route on SELECT entry: round-robin pointer or clamped manual pick
    always_comb begin
        w_load_ch = 3'd0;
        if (auto_scan) begin
            w_load_ch = r_next_ch;
        end else if ({1'b0, ch_sel} < 4'(NUM_CH)) begin
            w_load_ch = ch_sel;
        end
    end

    // Two-flop synchronizer on the routed wave plus the edge-history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= w_wave_pad[r_cur_ch];
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Scan sequencer: settle, arm on first edge, accumulate intervals, present result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_settle      <= '0;
            r_per         <= '0;
            r_tmo         <= '0;
            r_smp         <= '0;
            r_acc         <= '0;
            r_cur_ch      <= 3'd0;
            r_next_ch     <= 3'd0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= 3'd0;
            r_res_period  <= '0;
            r_res_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state   <= S_SELECT;
                        r_busy    <= 1'b1;
                        r_cur_ch  <= w_load_ch;
                        r_next_ch <= w_next_after;
                        r_settle  <= '0;
                    end
                end
                S_SELECT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_settle == SET_LAST) begin
                        r_state <= S_ARM;
                        r_tmo   <= '0;
                        r_smp   <= '0;
                        r_acc   <= '0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_ARM: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_rise) begin
                        // An edge on the timeout cycle still counts as activity
                        r_per   <= CNT_W'(1);
                        r_tmo   <= '0;
                        r_state <= S_MEASURE;
                    end else if (w_tmo_hit) begin
                        r_res_period  <= '0;
                        r_res_timeout <= 1'b1;
                        r_res_ch      <= r_cur_ch;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_PRESENT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_rise) begin
                        r_acc <= w_sum;
                        r_smp <= r_smp + 1'b1;
                        r_per <= CNT_W'(1);
                        r_tmo <= '0;
                        if (r_smp == SMP_LAST) begin
                            r_res_period  <= w_sum[ACC_W-1:AVG_LOG2];
                            r_res_timeout <= 1'b0;
                            r_res_ch      <= r_cur_ch;
                            r_res_valid   <= 1'b1;
                            r_state       <= S_PRESENT;
                        end
                    end else begin
                        r_per <= w_per_inc;
                        if (w_tmo_hit) begin
                            r_res_period  <= '0;
                            r_res_timeout <= 1'b1;
                            r_res_ch      <= r_cur_ch;
                            r_res_valid   <= 1'b1;
                            r_state       <= S_PRESENT;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                S_PRESENT: begin
                    // The pending result is delivered even if enable has dropped
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (enable) begin
                            r_state   <= S_SELECT;
                            r_cur_ch  <= w_load_ch;
                            r_next_ch <= w_next_after;
                            r_settle  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_period  = r_res_period;
    assign res_timeout = r_res_timeout;
    assign busy        = r_busy;
    assign cur_ch      = r_cur_ch;

endmodule

// File: doc/period_scan_ctrl.md
# period_scan_ctrl

Measurement sequencer for the tuner's period-measurement path. It scans the string inputs one at a time, either round-robin or on a fixed channel. For each channel it synchronizes the selected wave, times 2^AVG_LOG2 consecutive rising-edge-to-rising-edge intervals in clock cycles and averages them. It then presents one result per channel over a valid/ready handshake to the note-detection logic. Results are in clock cycles; conversion to ns or Hz happens downstream.

## Interface
- NUM_CH, 6: number of wave inputs (strings); 2..8
- CNT_W, 20: period counter / result width in cycles
- AVG_LOG2, 2: log2 of intervals averaged per result
- SETTLE, 4: cycles waited after a channel switch before edge detection
- TIMEOUT, 500000: cycles with no rising edge before a channel is declared silent; must be < 2^CNT_W

- clk  in  1  system clock (10 MHz)
- rst  in  1  asynchronous, active-high reset
- wave_in  in  NUM_CH  raw square-wave inputs, asynchronous to clk
- enable  in  1  1 = run scanning, 0 = go idle
- auto_scan  in  1  1 = round-robin channels, 0 = fixed channel ch_sel
- ch_sel  in  3  fixed channel in manual mode
- res_ready  in  1  consumer accepts result
- res_valid  out  1  result available
- res_ch  out  3  channel of the result
- res_period  out  CNT_W  averaged period in cycles; 0 on timeout
- res_timeout  out  1  channel produced no edges within TIMEOUT
- busy  out  1  high in every state except IDLE
- cur_ch  out  3  channel currently routed to the synchronizer

## Operation
- Input path: wave_in[cur_ch] is muxed, then passed through a 2-flop synchronizer (s1, s2) and an edge register s3. A rising edge is s2 & ~s3.
- States: IDLE, SELECT, ARM, MEASURE, PRESENT.
- IDLE: outputs hold, busy=0. If enable=1, go to SELECT.
- SELECT:
  - On entry, cur_ch is loaded. Manual mode uses ch_sel, with ch_sel >= NUM_CH treated as 0. Auto mode uses the next channel (see below).
  - Wait SETTLE cycles, then go to ARM. No edges are recognized here.
- ARM:
  - Clear the timeout counter, sample count and accumulator.
  - On the first rising edge, load period counter = 1 and go to MEASURE.
- MEASURE:
  - The period counter increments every cycle.
  - On each rising edge: accumulator += counter, sample count += 1, counter reloads to 1.
  - After 2^AVG_LOG2 samples: res_period = accumulator >> AVG_LOG2 (truncating), then go to PRESENT.
- Timeout counter: cleared on each rising edge and on ARM entry; increments in ARM and MEASURE. When it reaches TIMEOUT, go to PRESENT with res_timeout=1 and res_period=0.
- Period counter: saturates at 2^CNT_W-1 and never wraps.
- Accumulator width: CNT_W+AVG_LOG2, so no overflow is possible.
- PRESENT:
  - res_valid=1; res_ch, res_period and res_timeout are stable until accepted.
  - On res_valid & res_ready: res_valid drops next cycle. Go to SELECT if enable=1, else IDLE.
- Auto mode: the next channel is cur_ch+1, wrapping from NUM_CH-1 to 0. The first channel after reset is 0.
- enable=0 in SELECT, ARM or MEASURE aborts to IDLE next cycle. No result is produced. In PRESENT, the pending result is still delivered.
- ch_sel and auto_scan are sampled only on SELECT entry; changes mid-measurement are ignored.
- Reset values: res_valid=0, res_ch=0, res_period=0, res_timeout=0, busy=0, cur_ch=0. Synchronizer flops, all counters and the state also clear (state = IDLE).

## Timing
- Edge detection latency: 3 clk from wave_in rising (s1, s2, s3 compare).
- Measured interval = cycles between consecutive detected edges. For an ideal input of period P cycles, each sample = P, ±1 for synchronizer jitter.
- Result latency from ARM entry: wait for the first edge, plus 2^AVG_LOG2 × P, plus 1 cycle to register the result.
- res_valid rises the cycle after the final edge (or after timeout). res_valid must not drop without res_ready.
- Same-cycle rising edge and timeout: the edge wins and the timeout counter clears.
- Same-cycle enable=0 and final edge: the abort wins; no result.
- Back-to-back results: with res_ready tied high there is a 1-cycle PRESENT, then SELECT. Minimum spacing = SETTLE + 2 + edge wait + measurement.
- Async rst mid-measurement: res_valid=0 immediately; scan restarts at channel 0 after release.

## Test plan
- Manual mode, ch_sel=2, wave_in[2] period 1000 cycles, res_ready=1 → res_valid with res_ch=2, res_period=1000±1, res_timeout=0.
- Auto mode, channel i with period 1000·(i+1) cycles → results in order ch 0,1,2,3,4,5,0…, each res_period ≈1000·(i+1).
- Auto mode, channel 3 held low → res_ch=3, res_timeout=1, res_period=0, asserted TIMEOUT cycles after ARM entry; scan continues to channel 4.
- res_ready=0 for 50 cycles during PRESENT → res_valid, res_ch and res_period stay constant; a single acceptance occurs on the first res_ready=1.
- Input alternating periods 999 and 1001 (AVG_LOG2=2) → res_period=1000; all-999 input → 999 (truncation checked with a sum of 3997 → 999).
- enable=0 during MEASURE → IDLE next cycle, no res_valid. Async rst during PRESENT → res_valid=0 immediately, cur_ch=0 after release.
